// File: rtl/dds_voice_cfg_ctrl.sv
// Byte-serial configuration sequencer for the two-voice DDS core: stages tuning/select
// writes in shadow registers and moves them to the active outputs together on a divided-clock tick.
module dds_voice_cfg_ctrl #(
    parameter int TUNE_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic [TUNE_W-1:0] tuning0,
    output logic [TUNE_W-1:0] tuning1,
    output logic [SEL_W-1:0]  sel0,
    output logic [SEL_W-1:0]  sel1,
    output logic              psel,
    output logic              osel,
    output logic              applied,
    output logic              err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TUNE_HI   = 3'd1;
    localparam logic [2:0] S_TUNE_LO   = 3'd2;
    localparam logic [2:0] S_CFG_DATA  = 3'd3;
    localparam logic [2:0] S_WAIT_TICK = 3'd4;

    localparam logic [1:0] OP_TUNE   = 2'b00;
    localparam logic [1:0] OP_CFG    = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;

    logic [2:0]        state_q;
    logic [7:0]        hi_q;
    logic              voice_q;
    logic [TUNE_W-1:0] sh_tuning0;
    logic [TUNE_W-1:0] sh_tuning1;
    logic [SEL_W-1:0]  sh_sel0;
    logic [SEL_W-1:0]  sh_sel1;
    logic              sh_psel;
    logic              sh_osel;

    logic       accept;
    logic [1:0] opcode;
    logic       hdr_voice;
    logic       hdr_bad;
    logic [15:0] tune_word;

    assign accept    = wr_valid && wr_ready;
    assign opcode    = wr_data[7:6];
    assign hdr_voice = wr_data[0];
    // Only TUNE may address voice 1; every other opcode must carry v=0.
    assign hdr_bad   = (|wr_data[5:1]) || (hdr_voice && (opcode != OP_TUNE));
    assign tune_word = {hi_q, wr_data};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            voice_q    <= 1'b0;
            wr_ready   <= 1'b1;
            applied    <= 1'b0;
            err        <= 1'b0;
            tuning0    <= '0;
            tuning1    <= '0;
            sel0       <= '0;
            sel1       <= '0;
            psel       <= 1'b1;
            osel       <= 1'b0;
            sh_tuning0 <= '0;
            sh_tuning1 <= '0;
            sh_sel0    <= '0;
            sh_sel1    <= '0;
            sh_psel    <= 1'b1;
            sh_osel    <= 1'b0;
        end else begin
            applied <= 1'b0;
            err     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err <= 1'b1;
                        end else begin
                            case (opcode)
                                OP_TUNE: begin
                                    voice_q <= hdr_voice;
                                    state_q <= S_TUNE_HI;
                                end
                                OP_CFG:    state_q <= S_CFG_DATA;
                                OP_COMMIT: begin
                                    state_q  <= S_WAIT_TICK;
                                    wr_ready <= 1'b0;
                                end
                                default: begin
                                    sh_tuning0 <= tuning0;
                                    sh_tuning1 <= tuning1;
                                    sh_sel0    <= sel0;
                                    sh_sel1    <= sel1;
                                    sh_psel    <= psel;
                                    sh_osel    <= osel;
                                end
                            endcase
                        end
                    end
                end
                S_TUNE_HI: begin
                    if (accept) begin
                        hi_q    <= wr_data;
                        state_q <= S_TUNE_LO;
                    end
                end
                S_TUNE_LO: begin
                    if (accept) begin
                        if (voice_q) sh_tuning1 <= tune_word[TUNE_W-1:0];
                        else         sh_tuning0 <= tune_word[TUNE_W-1:0];
                        state_q <= S_IDLE;
                    end
                end
                S_CFG_DATA: begin
                    if (accept) begin
                        sh_psel <= wr_data[7];
                        sh_osel <= wr_data[6];
                        sh_sel0 <= SEL_W'(wr_data[5:3]);
                        sh_sel1 <= SEL_W'(wr_data[2:0]);
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_TICK: begin
                    // The COMMIT byte is accepted from IDLE, so a coincident tick never lands here.
                    if (tick) begin
                        tuning0  <= sh_tuning0;
                        tuning1  <= sh_tuning1;
                        sel0     <= sh_sel0;
                        sel1     <= sh_sel1;
                        psel     <= sh_psel;
                        osel     <= sh_osel;
                        applied  <= 1'b1;
                        wr_ready <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_voice_cfg_ctrl.sv
// Directed self-checking bench for dds_voice_cfg_ctrl: framed byte commands, commit/tick
// timing, malformed headers, revert and mid-frame reset.
module tb_dds_voice_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [15:0] tuning0;
    logic [15:0] tuning1;
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic        psel;
    logic        osel;
    logic        applied;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    dds_voice_cfg_ctrl #(.TUNE_W(16), .SEL_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tuning0  (tuning0),
        .tuning1  (tuning1),
        .sel0     (sel0),
        .sel1     (sel1),
        .psel     (psel),
        .osel     (osel),
        .applied  (applied),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1ns later with inputs idle.
    task automatic step(input logic v, input logic [7:0] d, input logic t);
        wr_valid = v;
        wr_data  = d;
        tick     = t;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tick     = 1'b0;
    endtask

    task automatic check_actives(input string tag, input logic [15:0] t0, input logic [15:0] t1,
                                 input logic [2:0] s0, input logic [2:0] s1,
                                 input logic p, input logic o);
        check({tag, ".tuning0"}, 32'(tuning0), 32'(t0));
        check({tag, ".tuning1"}, 32'(tuning1), 32'(t1));
        check({tag, ".sel0"},    32'(sel0),    32'(s0));
        check({tag, ".sel1"},    32'(sel1),    32'(s1));
        check({tag, ".psel"},    32'(psel),    32'(p));
        check({tag, ".osel"},    32'(osel),    32'(o));
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1);

        // Reset state
        check_actives("reset", 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b0);
        check("reset.wr_ready", 32'(wr_ready), 32'd1);
        check("reset.applied",  32'(applied),  32'd0);
        check("reset.err",      32'(err),      32'd0);
        rst = 1'b0;

        // TUNE voice 0 = 1234, COMMIT, tick five cycles later
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        check("t1.shadow_only", 32'(tuning0), 32'h0000);
        step(1'b1, 8'h80, 1'b0);
        check("t1.ready_low", 32'(wr_ready), 32'd0);
        step(1'b1, 8'h22, 1'b0);   // offered while not ready: must be ignored
        check("t1.no_err_when_blocked", 32'(err), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t1.still_waiting", 32'(wr_ready), 32'd0);
        check("t1.not_loaded",    32'(tuning0),  32'h0000);
        check("t1.applied_quiet", 32'(applied),  32'd0);
        step(1'b0, 8'h00, 1'b1);
        check_actives("t1.commit", 16'h1234, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b0);
        check("t1.applied", 32'(applied),  32'd1);
        check("t1.ready",   32'(wr_ready), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("t1.applied_once", 32'(applied), 32'd0);

        // TUNE voice 1 = ABCD plus CFG E5, single commit updates everything together
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hAB, 1'b0);
        step(1'b1, 8'hCD, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'hE5, 1'b0);
        step(1'b0, 8'h00, 1'b1);   // tick in IDLE changes nothing
        check_actives("t2.idle_tick", 16'h1234, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_actives("t2.commit", 16'h1234, 16'hABCD, 3'd4, 3'd5, 1'b1, 1'b1);
        check("t2.applied", 32'(applied), 32'd1);

        // COMMIT accepted in the same cycle as a tick: load waits for the next tick
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h80, 1'b1);
        check("t3.same_cycle_tick", 32'(tuning0),  32'h1234);
        check("t3.same_cycle_app",  32'(applied),  32'd0);
        check("t3.ready_low",       32'(wr_ready), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("t3.hold", 32'(tuning0), 32'h1234);
        step(1'b0, 8'h00, 1'b1);
        check("t3.loaded",  32'(tuning0), 32'h1122);
        check("t3.applied", 32'(applied), 32'd1);

        // Malformed headers: reserved bits set, then CFG addressed to voice 1
        step(1'b1, 8'h22, 1'b0);
        check("t4.err_reserved", 32'(err), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("t4.err_pulse", 32'(err), 32'd0);
        step(1'b1, 8'h41, 1'b0);
        check("t4.err_cfg_v1", 32'(err), 32'd1);
        step(1'b1, 8'h80, 1'b0);   // treated as a header only if FSM stayed IDLE
        check("t4.err_clear", 32'(err), 32'd0);
        check("t4.commit_hdr", 32'(wr_ready), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check_actives("t4.unchanged", 16'h1122, 16'hABCD, 3'd4, 3'd5, 1'b1, 1'b1);

        // REVERT discards a staged tuning word
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b1, 8'hC0, 1'b0);
        check("t5.revert_no_err", 32'(err), 32'd0);
        step(1'b1, 8'h80, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("t5.reverted", 32'(tuning0), 32'h1122);
        check("t5.applied",  32'(applied), 32'd1);

        // Reset while in TUNE_LO drops the staged byte and restores reset values
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check_actives("t6.reset", 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b0);
        check("t6.ready", 32'(wr_ready), 32'd1);
        step(1'b1, 8'h88, 1'b0);   // would be a low byte had the frame survived
        check("t6.idle_after_reset", 32'(err), 32'd1);
        step(1'b1, 8'h80, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("t6.shadow_reset", 32'(tuning0), 32'h0000);
        check("t6.applied",      32'(applied), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
